// File: rtl/ann_layer_engine.sv
// Time-multiplexed multi-layer perceptron engine.
//
// A bank of MAX_NODES MAC lanes evaluates NUM_LAYERS fully-connected layers one after another.
// The engine captures an image over a valid/ready stream and stores it in the activation
// buffer. It then streams one coefficient vector per input element. Each layer result is
// shifted, rectified on hidden layers, saturated and written back into the same buffer. A
// sequential argmax over the final layer produces the winning class.
//
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   start, abort            run request (IDLE only), synchronous abort to IDLE
//   layer_nodes             per-layer node counts, layer 0 at the LSBs, latched on start
//   img_valid/ready/data    image stream, element 0 first
//   coef_valid/ready/data   coefficient stream, lane j = weight to node j
//   layer_idx               current layer, selects the coefficient source
//   busy, done              run in progress, single-cycle completion pulse
//   class_idx, class_score  winning node and its activation
module ann_layer_engine #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned IMAGE_SIZE = 64,
  parameter int unsigned MAX_NODES  = 16,
  parameter int unsigned NUM_LAYERS = 3,
  localparam int unsigned NODE_W    = $clog2(MAX_NODES + 1),
  localparam int unsigned IDX_W     = $clog2(MAX_NODES),
  localparam int unsigned LAYER_W   = $clog2(NUM_LAYERS + 1)
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_LAYERS*NODE_W-1:0]   layer_nodes,
  input  logic                           img_valid,
  output logic                           img_ready,
  input  logic [DATA_W-1:0]              img_data,
  input  logic                           coef_valid,
  output logic                           coef_ready,
  input  logic [MAX_NODES*DATA_W-1:0]    coef_data,
  output logic [LAYER_W-1:0]             layer_idx,
  output logic                           busy,
  output logic                           done,
  output logic [IDX_W-1:0]               class_idx,
  output logic [DATA_W-1:0]              class_score
);

  localparam int unsigned CNT_W  = $clog2(IMAGE_SIZE + 1);
  localparam int unsigned ADDR_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int unsigned LSEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoad, StMac, StAct, StArgmax, StDone} state_e;

  state_e                   state;
  logic [NODE_W-1:0]        nodes   [NUM_LAYERS];
  logic signed [DATA_W-1:0] act_buf [IMAGE_SIZE];
  logic signed [ACC_W-1:0]  acc     [MAX_NODES];
  logic [CNT_W-1:0]         k;
  logic [CNT_W-1:0]         n_in;
  logic signed [DATA_W-1:0] best_val;
  logic [IDX_W-1:0]         best_idx;

  logic [NODE_W-1:0]        cur_nodes;
  logic signed [DATA_W-1:0] cur_in;
  logic                     last_layer;
  logic signed [ACC_W-1:0]  mac_sum [MAX_NODES];
  logic signed [DATA_W-1:0] act_val [MAX_NODES];
  logic                     scan_better;

  // 0 nodes would leave the argmax with nothing to scan; more than MAX_NODES has no lane.
  function automatic logic [NODE_W-1:0] clamp_nodes(input logic [NODE_W-1:0] n);
    if (n == '0) return NODE_W'(1);
    if (n > NODE_W'(MAX_NODES)) return NODE_W'(MAX_NODES);
    return n;
  endfunction

  always_comb begin
    cur_nodes   = nodes[layer_idx[LSEL_W-1:0]];
    cur_in      = act_buf[k[ADDR_W-1:0]];
    last_layer  = (layer_idx == LAYER_W'(NUM_LAYERS - 1));
    // Strictly greater only, so ties keep the lowest index.
    scan_better = (k == '0) || (cur_in > best_val);
    for (int j = 0; j < MAX_NODES; j++) begin
      logic signed [PROD_W-1:0] prod;
      logic signed [ACC_W-1:0]  shifted;
      prod       = PROD_W'(cur_in) * PROD_W'($signed(coef_data[j*DATA_W +: DATA_W]));
      mac_sum[j] = acc[j] + ACC_W'(prod);
      shifted    = acc[j] >>> FRAC_BITS;
      if (!last_layer && shifted[ACC_W-1]) shifted = '0;
      if (shifted > SatMax)      act_val[j] = SatMax[DATA_W-1:0];
      else if (shifted < SatMin) act_val[j] = SatMin[DATA_W-1:0];
      else                       act_val[j] = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      img_ready   <= 1'b0;
      coef_ready  <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      layer_idx   <= '0;
      k           <= '0;
      n_in        <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      for (int l = 0; l < NUM_LAYERS; l++) nodes[l] <= '0;
      for (int i = 0; i < IMAGE_SIZE; i++) act_buf[i] <= '0;
      for (int j = 0; j < MAX_NODES; j++) acc[j] <= '0;
    end else if (abort) begin
      state       <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      img_ready   <= 1'b0;
      coef_ready  <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      layer_idx   <= '0;
      k           <= '0;
      // A partial layer must not leak into the next run.
      for (int j = 0; j < MAX_NODES; j++) acc[j] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
              nodes[l] <= clamp_nodes(layer_nodes[l*NODE_W +: NODE_W]);
            end
            for (int j = 0; j < MAX_NODES; j++) acc[j] <= '0;
            n_in      <= CNT_W'(IMAGE_SIZE);
            layer_idx <= '0;
            k         <= '0;
            busy      <= 1'b1;
            img_ready <= 1'b1;
            state     <= StLoad;
          end
        end
        StLoad: begin
          if (img_valid && img_ready) begin
            act_buf[k[ADDR_W-1:0]] <= img_data;
            if (k == CNT_W'(IMAGE_SIZE - 1)) begin
              k          <= '0;
              img_ready  <= 1'b0;
              coef_ready <= 1'b1;
              state      <= StMac;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        StMac: begin
          if (coef_valid && coef_ready) begin
            for (int j = 0; j < MAX_NODES; j++) begin
              if (NODE_W'(j) < cur_nodes) acc[j] <= mac_sum[j];
            end
            if (k == n_in - 1'b1) begin
              k          <= '0;
              coef_ready <= 1'b0;
              state      <= StAct;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        StAct: begin
          for (int j = 0; j < MAX_NODES; j++) begin
            act_buf[j] <= (NODE_W'(j) < cur_nodes) ? act_val[j] : '0;
            acc[j]     <= '0;
          end
          n_in <= CNT_W'(cur_nodes);
          if (last_layer) begin
            state <= StArgmax;
          end else begin
            layer_idx  <= layer_idx + 1'b1;
            coef_ready <= 1'b1;
            state      <= StMac;
          end
        end
        StArgmax: begin
          if (scan_better) begin
            best_val <= cur_in;
            best_idx <= k[IDX_W-1:0];
          end
          if (k == CNT_W'(cur_nodes - 1'b1)) begin
            class_idx   <= scan_better ? k[IDX_W-1:0] : best_idx;
            class_score <= scan_better ? cur_in : best_val;
            done        <= 1'b1;
            k           <= '0;
            state       <= StDone;
          end else begin
            k <= k + 1'b1;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
